// File: rtl/pll_pkg.sv
// -----------------------------------------------------------------------------
// pll_pkg
//   Shared definitions for the PLL observability blocks.
//   meter_state_t : state of the period meter
//     ARM     - waiting for the first toggle (first interval is partial)
//     MEASURE - producing measurements, not yet stable
//     LOCKED  - the last LOCK_COUNT measurements were identical
// -----------------------------------------------------------------------------
package pll_pkg;

    typedef enum logic [1:0] {
        ARM     = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } meter_state_t;

endpackage

// File: rtl/sync_toggle_detect.sv
// -----------------------------------------------------------------------------
// sync_toggle_detect
//   Brings an asynchronous level into the i_clk domain through a SYNC_STAGES
//   flop chain, keeps one more delayed copy, and flags any change (rising or
//   falling) between the two as a single-cycle toggle.
//
//   Ports
//     i_clk    : sampling clock
//     i_rst_n  : asynchronous active-low reset, all flops clear to 0
//     i_async  : asynchronous input level
//     o_toggle : high for one cycle per synchronised edge of i_async
// -----------------------------------------------------------------------------
module sync_toggle_detect #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_toggle
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_last;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '0;
            r_last <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_last <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_toggle = r_sync[SYNC_STAGES-1] ^ r_last;

endmodule

// File: rtl/freq_divider_period_meter.sv
// -----------------------------------------------------------------------------
// freq_divider_period_meter
//   Measures the half-period of a divided clock in cycles of the fast clock
//   and reports it in the even divider's halfdivisor encoding (interval - 1).
//   Asserts locked once LOCK_COUNT consecutive measurements agree.
//
//   Ports
//     in             : fast clock, all state updates on posedge
//     reset          : asynchronous active-low reset
//     div_in         : divided waveform, asynchronous to in
//     measured       : last valid half-period measurement
//     measured_valid : one-cycle pulse when measured updates
//     locked         : high while in the LOCKED state
//     overflow       : one-cycle pulse when an interval exceeds 2^N cycles
// -----------------------------------------------------------------------------
module freq_divider_period_meter
    import pll_pkg::*;
#(
    parameter int unsigned NUM_DIVISOR_BITS = 4,
    parameter int unsigned LOCK_COUNT       = 4,
    parameter int unsigned SYNC_STAGES      = 2
) (
    input  logic                        in,
    input  logic                        reset,
    input  logic                        div_in,
    output logic [NUM_DIVISOR_BITS-1:0] measured,
    output logic                        measured_valid,
    output logic                        locked,
    output logic                        overflow
);

    localparam int unsigned MW = $clog2(LOCK_COUNT);
    localparam logic [MW-1:0] MATCH_MAX = MW'(LOCK_COUNT - 1);

    logic                        w_toggle;
    logic [NUM_DIVISOR_BITS-1:0] r_cnt;
    logic                        r_sat;
    meter_state_t                r_state;
    logic [NUM_DIVISOR_BITS-1:0] r_measured;
    logic                        r_valid;
    logic                        r_overflow;
    logic [MW-1:0]               r_match;
    logic [MW-1:0]               w_match_inc;

    sync_toggle_detect #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .i_clk    (in),
        .i_rst_n  (reset),
        .i_async  (div_in),
        .o_toggle (w_toggle)
    );

    // Interval counter. Reading all-ones on a non-toggle cycle means the
    // interval is already longer than 2^N, so sat latches and the counter
    // parks at all-ones until the next toggle.
    always_ff @(posedge in or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
            r_sat <= 1'b0;
        end else if (w_toggle) begin
            r_cnt <= '0;
            r_sat <= 1'b0;
        end else if (!r_sat) begin
            if (r_cnt == '1) begin
                r_sat <= 1'b1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign w_match_inc = (r_match == MATCH_MAX) ? MATCH_MAX : r_match + 1'b1;

    // Measurement FSM with registered outputs. The first toggle after reset
    // only arms the meter since the interval before it is partial.
    always_ff @(posedge in or negedge reset) begin
        if (!reset) begin
            r_state    <= ARM;
            r_measured <= '0;
            r_valid    <= 1'b0;
            r_overflow <= 1'b0;
            r_match    <= '0;
        end else begin
            r_valid    <= 1'b0;
            r_overflow <= 1'b0;
            if (w_toggle) begin
                case (r_state)
                    ARM: begin
                        r_state <= MEASURE;
                    end
                    default: begin
                        if (r_sat) begin
                            r_overflow <= 1'b1;
                            r_match    <= '0;
                            r_state    <= MEASURE;
                        end else begin
                            r_measured <= r_cnt;
                            r_valid    <= 1'b1;
                            // Compared against the previous measured value,
                            // which is the reset value 0 right after ARM.
                            if (r_cnt == r_measured) begin
                                r_match <= w_match_inc;
                                r_state <= (w_match_inc == MATCH_MAX) ? LOCKED : MEASURE;
                            end else begin
                                r_match <= '0;
                                r_state <= MEASURE;
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign measured       = r_measured;
    assign measured_valid = r_valid;
    assign overflow       = r_overflow;
    assign locked         = (r_state == LOCKED);

endmodule

// File: tb/tb_freq_divider_period_meter.sv
module tb_freq_divider_period_meter;

    localparam int unsigned N    = 4;
    localparam int unsigned LC   = 4;
    localparam int unsigned S    = 2;
    localparam int          MAXV = (1 << N) - 1;

    logic         in     = 1'b0;
    logic         reset  = 1'b0;
    logic         div_in = 1'b0;
    logic [N-1:0] measured;
    logic         measured_valid;
    logic         locked;
    logic         overflow;

    freq_divider_period_meter #(
        .NUM_DIVISOR_BITS (N),
        .LOCK_COUNT       (LC),
        .SYNC_STAGES      (S)
    ) dut (
        .in             (in),
        .reset          (reset),
        .div_in         (div_in),
        .measured       (measured),
        .measured_valid (measured_valid),
        .locked         (locked),
        .overflow       (overflow)
    );

    always #5 in = ~in;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: div_in history sampled per edge, the gap since the
    // last detected toggle, and the run length of identical measurements.
    logic         dq[$];
    bit           armed;
    int           gap;
    int           run;
    logic [N-1:0] m_meas;
    bit           m_valid;
    bit           m_ovf;

    // per-row statistics taken from the DUT outputs
    int row_valids, row_ovfs, row_ev, row_rise, row_drop;
    bit prev_lk = 1'b0;

    typedef struct {
        int period;
        int ntog;
        int tail;
        int exp_meas;
        int exp_lock;
        int exp_valids;
        int exp_ovfs;
        int exp_rise;
        int exp_drop;
    } row_t;

    row_t rows[5];

    function automatic void model_reset();
        dq.delete();
        for (int i = 0; i < int'(S) + 1; i++) dq.push_back(1'b0);
        armed   = 1'b0;
        gap     = 0;
        run     = 1;
        m_meas  = '0;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
    endfunction

    function automatic void model_edge(logic d);
        bit tog;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
        dq.push_back(d);
        if (dq.size() > int'(S) + 2) void'(dq.pop_front());
        tog = (dq[0] != dq[1]);
        if (tog) begin
            if (!armed) begin
                armed = 1'b1;
            end else if (gap <= MAXV) begin
                m_valid = 1'b1;
                if (gap == int'(m_meas)) run = (run < int'(LC)) ? run + 1 : run;
                else                     run = 1;
                m_meas = N'(gap);
            end else begin
                m_ovf = 1'b1;
                run   = 1;
            end
            gap = 0;
        end else if (gap < 1000) begin
            gap++;
        end
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic cmp_model(input string tag);
        cmp({tag, ".measured"}, 32'(measured),       32'(m_meas));
        cmp({tag, ".valid"},    32'(measured_valid), 32'(m_valid));
        cmp({tag, ".locked"},   32'(locked),         32'(run >= int'(LC)));
        cmp({tag, ".overflow"}, 32'(overflow),       32'(m_ovf));
    endtask

    task automatic cmp_zero(input string tag);
        cmp({tag, ".measured"}, 32'(measured),       32'd0);
        cmp({tag, ".valid"},    32'(measured_valid), 32'd0);
        cmp({tag, ".locked"},   32'(locked),         32'd0);
        cmp({tag, ".overflow"}, 32'(overflow),       32'd0);
    endtask

    // One clock: model steps on posedge, DUT checked on the following negedge.
    task automatic tick(input string tag);
        @(posedge in);
        if (reset) model_edge(div_in);
        else       model_reset();
        @(negedge in);
        cmp_model(tag);
        if (measured_valid) row_valids++;
        if (overflow)       row_ovfs++;
        if (measured_valid || overflow) row_ev++;
        if (locked && !prev_lk) row_rise = row_ev;
        if (!locked && prev_lk) row_drop = row_ev;
        prev_lk = locked;
    endtask

    // ntog toggles spaced 'period' cycles; the last one is followed by 'tail'.
    task automatic run_row(input int period, input int ntog, input int tail, input string tag);
        row_valids = 0;
        row_ovfs   = 0;
        row_ev     = 0;
        row_rise   = 0;
        row_drop   = 0;
        for (int t = 0; t < ntog; t++) begin
            div_in = ~div_in;
            repeat ((t == ntog - 1) ? tail : period) tick(tag);
        end
    endtask

    task automatic async_reset(input string tag);
        reset = 1'b0;
        model_reset();
        #1;
        cmp_zero(tag);
        prev_lk = 1'b0;
    endtask

    initial begin
        rows[0] = '{1,  8, 6,  0,  1, 7, 0, 3, 0};
        rows[1] = '{6,  8, 9,  5,  1, 8, 0, 4, 1};
        rows[2] = '{9,  6, 16, 8,  1, 6, 0, 4, 1};
        rows[3] = '{16, 6, 17, 15, 1, 6, 0, 4, 1};
        rows[4] = '{17, 3, 20, 15, 0, 0, 3, 0, 1};

        model_reset();
        @(negedge in);
        cmp_zero("reset");

        // reset held low while div_in toggles: everything stays 0
        for (int i = 0; i < 6; i++) begin
            div_in = ~div_in;
            tick("rst_hold");
        end
        cmp_zero("rst_hold_end");
        reset = 1'b1;

        // table-driven rows; row 0's first toggle is the ARM edge
        for (int r = 0; r < 5; r++) begin
            run_row(rows[r].period, rows[r].ntog, rows[r].tail, $sformatf("row%0d", r));
            cmp($sformatf("row%0d.measured", r), 32'(measured),   32'(rows[r].exp_meas));
            cmp($sformatf("row%0d.locked", r),   32'(locked),     32'(rows[r].exp_lock));
            cmp($sformatf("row%0d.valids", r),   32'(row_valids), 32'(rows[r].exp_valids));
            cmp($sformatf("row%0d.ovfs", r),     32'(row_ovfs),   32'(rows[r].exp_ovfs));
            cmp($sformatf("row%0d.rise_at", r),  32'(row_rise),   32'(rows[r].exp_rise));
            cmp($sformatf("row%0d.drop_at", r),  32'(row_drop),   32'(rows[r].exp_drop));
        end

        // lock at 4, then reset mid-interval
        run_row(5, 6, 2, "midlock");
        cmp("midlock.locked",   32'(locked),   32'd1);
        cmp("midlock.measured", 32'(measured), 32'd4);
        async_reset("midlock_async");
        div_in = 1'b0;
        repeat (3) tick("midlock_hold");
        reset = 1'b1;
        repeat (3) tick("rearm_idle");
        run_row(4, 3, 6, "rearm");
        cmp("rearm.valids",   32'(row_valids), 32'd2);
        cmp("rearm.ovfs",     32'(row_ovfs),   32'd0);
        cmp("rearm.measured", 32'(measured),   32'd3);
        cmp("rearm.locked",   32'(locked),     32'd0);

        // randomized periods against the model, with occasional resets
        for (int r = 0; r < 40; r++) begin
            int p;
            int nt;
            p  = int'($urandom_range(1, 20));
            nt = int'($urandom_range(1, 7));
            if ($urandom_range(0, 9) == 0) begin
                async_reset("rnd_async");
                if ($urandom_range(0, 1) == 1) div_in = ~div_in;
                repeat (2) tick("rnd_hold");
                reset = 1'b1;
            end
            run_row(p, nt, p, "rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
